// File: rtl/hzrd_sb.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations over NSTG
// stages, forwards the youngest ready producer and stalls on early loads.
module hzrd_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NSTG     = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_dec_vld,
    input  logic                 i_flush,
    input  logic                 i_hold,
    input  logic [AW-1:0]        i_rs1_raddr,
    input  logic [AW-1:0]        i_rs2_raddr,
    input  logic                 i_rs1_used,
    input  logic                 i_rs2_used,
    input  logic [AW-1:0]        i_rd_waddr,
    input  logic                 i_rd_wen,
    input  logic                 i_is_load,
    input  logic [XLEN-1:0]      i_rs1_rdata,
    input  logic [XLEN-1:0]      i_rs2_rdata,
    input  logic [NSTG*XLEN-1:0] i_stg_res,
    output logic [XLEN-1:0]      o_op1,
    output logic [XLEN-1:0]      o_op2,
    output logic [NSTG-1:0]      o_frwd1,
    output logic [NSTG-1:0]      o_frwd2,
    output logic                 o_stall,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [NSTG-1:0]      o_inflight
);

    logic [NSTG-1:0]         vld_q, vld_d;
    logic [NSTG-1:0]         ld_q, ld_d;
    logic [NSTG-1:0][AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NSTG-1:0] hit1, hit2, sel1, sel2, early;
    logic            haz1, haz2, acc, wr_vld;

    always_comb begin
        hit1  = '0;
        hit2  = '0;
        early = '0;
        for (int s = 0; s < NSTG; s++) begin
            hit1[s]  = vld_q[s] && (rd_q[s] == i_rs1_raddr)
                       && i_rs1_used && (i_rs1_raddr != '0);
            hit2[s]  = vld_q[s] && (rd_q[s] == i_rs2_raddr)
                       && i_rs2_used && (i_rs2_raddr != '0);
            early[s] = ld_q[s] && (s + 1 < LOAD_LAT);
        end
    end

    // Isolating the lowest set bit picks the youngest producer.
    assign sel1 = hit1 & ~(hit1 - NSTG'(1));
    assign sel2 = hit2 & ~(hit2 - NSTG'(1));
    assign haz1 = |(sel1 & early);
    assign haz2 = |(sel2 & early);

    assign o_frwd1 = haz1 ? '0 : sel1;
    assign o_frwd2 = haz2 ? '0 : sel2;
    assign o_stall = i_dec_vld & ~i_flush & (haz1 | haz2);

    always_comb begin
        o_op1 = i_rs1_rdata;
        o_op2 = i_rs2_rdata;
        for (int s = 0; s < NSTG; s++) begin
            if (o_frwd1[s]) o_op1 = i_stg_res[s*XLEN +: XLEN];
            if (o_frwd2[s]) o_op2 = i_stg_res[s*XLEN +: XLEN];
        end
    end

    assign acc    = i_dec_vld & ~i_flush & ~o_stall;
    assign wr_vld = acc & i_rd_wen & (i_rd_waddr != '0);

    always_comb begin
        vld_d = '0;
        ld_d  = '0;
        rd_d  = '0;
        for (int s = NSTG - 1; s > 0; s--) begin
            vld_d[s] = vld_q[s-1];
            ld_d[s]  = ld_q[s-1];
            rd_d[s]  = rd_q[s-1];
        end
        vld_d[0] = wr_vld;
        ld_d[0]  = wr_vld & i_is_load;
        rd_d[0]  = wr_vld ? i_rd_waddr : '0;
    end

    assign cnt_d = (o_stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            ld_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (!i_hold) begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_stall_cnt = cnt_q;
    assign o_inflight  = vld_q;

endmodule

// File: tb/tb_hzrd_sb.sv
// Scoreboard bench for hzrd_sb (NSTG=3, LOAD_LAT=2, CNT_W=2): directed
// cycles push expected outputs, a negedge monitor pops and compares.
module tb_hzrd_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NSTG = 3;
    localparam int CW   = 2;

    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    logic clk, rst_n;
    logic dec_vld, flush, hold;
    logic [AW-1:0] rs1, rs2, rd;
    logic u1, u2, wen, ld;
    logic [XLEN-1:0] s1v, s2v, s3v;
    logic [XLEN-1:0] op1, op2;
    logic [NSTG-1:0] f1, f2, infl;
    logic stall;
    logic [CW-1:0] cnt;

    hzrd_sb #(
        .XLEN(XLEN), .AW(AW), .NSTG(NSTG), .LOAD_LAT(2), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_dec_vld(dec_vld), .i_flush(flush), .i_hold(hold),
        .i_rs1_raddr(rs1), .i_rs2_raddr(rs2),
        .i_rs1_used(u1), .i_rs2_used(u2),
        .i_rd_waddr(rd), .i_rd_wen(wen), .i_is_load(ld),
        .i_rs1_rdata(R1), .i_rs2_rdata(R2),
        .i_stg_res({s3v, s2v, s1v}),
        .o_op1(op1), .o_op2(op2),
        .o_frwd1(f1), .o_frwd2(f2),
        .o_stall(stall), .o_stall_cnt(cnt),
        .o_inflight(infl)
    );

    typedef struct {
        string       nm;
        bit          chk_op;
        logic [31:0] op1, op2;
        logic [2:0]  f1, f2;
        logic        st;
        logic [1:0]  cnt;
        logic [2:0]  infl;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, string f, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s.%s got=%h exp=%h", nm, f, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "stall", 32'(stall), 32'(e.st));
            chk(e.nm, "cnt", 32'(cnt), 32'(e.cnt));
            chk(e.nm, "inflight", 32'(infl), 32'(e.infl));
            if (e.chk_op) begin
                chk(e.nm, "op1", op1, e.op1);
                chk(e.nm, "op2", op2, e.op2);
                chk(e.nm, "frwd1", 32'(f1), 32'(e.f1));
                chk(e.nm, "frwd2", 32'(f2), 32'(e.f2));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic fl, input logic h,
                       input logic [4:0] a1, input logic k1,
                       input logic [4:0] a2, input logic k2,
                       input logic [4:0] d, input logic w, input logic l);
        dec_vld = v; flush = fl; hold = h;
        rs1 = a1; u1 = k1; rs2 = a2; u2 = k2;
        rd = d; wen = w; ld = l;
    endtask

    task automatic idle;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ex(input string nm, input bit c,
                      input logic [31:0] o1, input logic [31:0] o2,
                      input logic [2:0] e1, input logic [2:0] e2,
                      input logic st, input logic [1:0] n,
                      input logic [2:0] inf);
        exp_t e;
        e.nm = nm; e.chk_op = c; e.op1 = o1; e.op2 = o2;
        e.f1 = e1; e.f2 = e2; e.st = st; e.cnt = n; e.infl = inf;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        s1v = 32'h0000_1234;
        s2v = 32'hBEEF_0002;
        s3v = 32'h3333_0003;
        idle();
        ex("reset", 1, R1, R2, 0, 0, 0, 0, 3'b000);
        tick(); tick();
        rst_n = 1'b1;

        // 1: no producers
        drv(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        ex("t1_rf", 1, R1, R2, 0, 0, 0, 0, 3'b000);
        tick();
        // 2: ALU producer forwarded from stage 1
        drv(1, 0, 0, 0, 0, 0, 0, 5, 1, 0);
        tick();
        drv(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        ex("t2_fwd1", 1, 32'h1234, R2, 3'b001, 0, 0, 0, 3'b001);
        tick();
        idle();
        ex("t2_shift", 1, R1, R2, 0, 0, 0, 0, 3'b010);
        tick();
        ex("t2_last", 1, R1, R2, 0, 0, 0, 0, 3'b100);
        tick();

        // 3: load-use on rs2
        drv(1, 0, 0, 0, 0, 0, 0, 7, 1, 1);
        ex("t3_load", 1, R1, R2, 0, 0, 0, 0, 3'b000);
        tick();
        drv(1, 0, 0, 0, 0, 7, 1, 8, 1, 0);
        ex("t3_stall", 0, 0, 0, 0, 0, 1, 0, 3'b001);
        tick();
        ex("t3_fwd2", 1, R1, 32'hBEEF_0002, 0, 3'b010, 0, 1, 3'b010);
        tick();
        idle();
        ex("t3_after", 1, R1, R2, 0, 0, 0, 1, 3'b101);
        tick(); tick(); tick();

        // 4: youngest of two producers; x0 reads and writes
        drv(1, 0, 0, 0, 0, 0, 0, 3, 1, 0);
        tick(); tick();
        s1v = 32'h0000_000A;
        s2v = 32'h0000_000B;
        drv(1, 0, 0, 3, 1, 0, 1, 0, 1, 0);
        ex("t4_young", 1, 32'hA, R2, 3'b001, 0, 0, 1, 3'b011);
        tick();
        drv(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        ex("t4_older", 1, 32'hB, R2, 3'b010, 0, 0, 1, 3'b110);
        tick();
        idle();
        tick();

        // 5a: flush beats hazard
        drv(1, 0, 0, 0, 0, 0, 0, 9, 1, 1);
        tick();
        drv(1, 1, 0, 9, 1, 0, 0, 10, 1, 0);
        ex("t5_flush", 0, 0, 0, 0, 0, 0, 1, 3'b001);
        tick();
        idle();
        ex("t5_bubble", 1, R1, R2, 0, 0, 0, 1, 3'b010);
        tick(); tick();

        // 5b: hold during stall freezes entries and count
        drv(1, 0, 0, 0, 0, 0, 0, 11, 1, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 1, 11, 1, 0, 0, 0, 0, 0);
            ex("t5_hold", 0, 0, 0, 0, 0, 1, 1, 3'b001);
            tick();
        end
        drv(1, 0, 0, 11, 1, 0, 0, 0, 0, 0);
        ex("t5_unhold", 0, 0, 0, 0, 0, 1, 1, 3'b001);
        tick();
        ex("t5_fwd", 1, 32'hB, R2, 3'b010, 0, 0, 2, 3'b010);
        tick();
        idle();
        tick();

        // 6: five stalls saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 0, 0, 0, 0, 5'(12 + i), 1, 1);
            tick();
            drv(1, 0, 0, 5'(12 + i), 1, 0, 0, 0, 0, 0);
            ex("t6_stall", 0, 0, 0, 0, 0, 1, (i == 0) ? 2'd2 : 2'd3,
               3'b001);
            tick();
            ex("t6_fwd", 1, 32'hB, R2, 3'b010, 0, 0, 3, 3'b010);
            tick();
        end

        // 6b: async reset mid-stall, between edges
        drv(1, 0, 0, 0, 0, 0, 0, 20, 1, 1);
        tick();
        drv(1, 0, 1, 20, 1, 0, 0, 0, 0, 0);
        ex("t6_pre_rst", 0, 0, 0, 0, 0, 1, 3, 3'b001);
        tick();
        #1;
        rst_n = 1'b0;
        ex("t6_async_rst", 1, R1, R2, 0, 0, 0, 0, 3'b000);
        tick();
        rst_n = 1'b1;
        idle();
        ex("post_rst", 1, R1, R2, 0, 0, 0, 0, 3'b000);
        tick();

        @(negedge clk);
        #1;
        chk("drain", "qsize", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hzrd_sb.md
Name: hzrd_sb

Overview:
- Parametrised scoreboard-based hazard detection and operand forwarding unit for the decode stage.
- Generalises the fixed three-source forwarding and single load-use check to a configurable number of tracked post-decode stages and a configurable load result latency.
- Tracks in-flight destination registers in a shift register.
- Selects the youngest producer for each source operand, stalls decode when the producer's result is not yet available, and counts stall cycles.

Parameters:
XLEN, 32, data width of operands and stage results
AW, 5, register address width
NSTG, 3, number of tracked stages after decode (1 = EX output, NSTG = last stage before register file write), legal range 1..8
LOAD_LAT, 2, first stage index whose result is valid for a load (1..NSTG)
CNT_W, 16, stall counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
i_dec_vld  in  1  decode holds a valid instruction
i_flush  in  1  discard decode instruction this cycle
i_hold  in  1  downstream hold; freezes the scoreboard
i_rs1_raddr  in  AW  decode rs1 address
i_rs2_raddr  in  AW  decode rs2 address
i_rs1_used  in  1  instruction reads rs1
i_rs2_used  in  1  instruction reads rs2
i_rd_waddr  in  AW  decode destination
i_rd_wen  in  1  decode instruction writes rd
i_is_load  in  1  decode instruction is a load
i_rs1_rdata  in  XLEN  register file rs1 data (register file bypasses writeback)
i_rs2_rdata  in  XLEN  register file rs2 data
i_stg_res  in  NSTG*XLEN  result of stage s in slice [s*XLEN-1 -: XLEN]
o_op1  out  XLEN  forwarded rs1 value
o_op2  out  XLEN  forwarded rs2 value
o_frwd1  out  NSTG  one-hot rs1 source stage; 0 = register file
o_frwd2  out  NSTG  one-hot rs2 source stage
o_stall  out  1  hold decode and fetch; insert bubble
o_stall_cnt  out  CNT_W  saturating count of stall cycles
o_inflight  out  NSTG  valid bits of scoreboard entries (debug)

Behaviour:
- Each scoreboard entry s = 1..NSTG holds vld, rd, rdy. The value of rdy is 1 for non-loads and LOAD_LAT for loads.
- Entry writes: vld is written only if i_rd_wen=1 and rd!=0; otherwise a bubble is written.
- Reset (i_rst_n=0, async): all entries invalid and o_stall_cnt=0.
  - Resulting combinational outputs: o_stall=0, o_frwd*=0, and o_op* = register file data.
- Lookup per operand, when rsN_used=1 and raddr!=0:
  - Match entry = smallest s with vld and rd==raddr; the youngest producer wins.
  - Match with s>=rdy: o_opN = i_stg_res slice s, o_frwdN = 1<<(s-1).
  - Match with s<rdy: hazard.
  - No match, raddr==0, or rsN_used=0: o_opN = i_rsN_rdata, o_frwdN = 0.
- Forwarding is purely combinational; there are no registered outputs.
- o_stall = i_dec_vld & !i_flush & (hazard1 | hazard2).
- Shift on posedge when i_hold=0:
  - entry[s+1] <= entry[s].
  - entry[NSTG] is retired; its result is written through the register file.
  - entry[1] <= decode record if i_dec_vld & !i_flush & !o_stall; otherwise a bubble.
- i_hold=1: all entries frozen; o_stall and forwarding are still evaluated every cycle.
- Simultaneous events:
  - Flush with hazard: flush wins, o_stall=0, bubble enters.
  - Flush with hold: entries frozen.
- o_stall_cnt increments by 1 each cycle with o_stall=1 and i_hold=0; it saturates at all-ones and never wraps.
- Reset asserted mid-stall clears the scoreboard immediately; o_stall drops the same cycle.
- Stall latency for a load-use pair: exactly LOAD_LAT-1 cycles when no hold intervenes.

Test Plan:
1. Reset, then decode reads x5 with no producers -> o_op1 = i_rs1_rdata, o_frwd1=000, o_stall=0, o_stall_cnt=0.
2. ALU writes x5, next cycle decode reads x5, i_stg_res slice1=0x1234 -> o_op1=0x1234, o_frwd1=001, no stall.
3. LOAD_LAT=2: load x7, next instruction reads x7 as rs2 -> o_stall=1 for 1 cycle. Next cycle o_frwd2=010, o_op2 = slice2 value, o_stall_cnt=1.
4. Two producers of x3 at stages 1 and 2 (slices 0xA, 0xB) -> o_op1=0xA, o_frwd1=001. Reads of x0 always give register file data.
5. Load-use hazard with i_flush=1 -> o_stall=0 and a bubble enters. Separately, i_hold=1 for 3 cycles during a stall -> entries and o_stall_cnt frozen, o_inflight unchanged.
6. CNT_W=2, force 5 stall cycles -> o_stall_cnt=3. Assert i_rst_n=0 asynchronously between clock edges -> count 0 and o_inflight=0 before the next edge.
